// File: rtl/rx_tx_axis_pkg.sv
// Shared RX/TX AXI-Stream lane definitions: bus widths, generator FSM states
// and the last-beat byte-enable decode used by both generator and checker.
package rx_tx_axis_pkg;

    localparam int DATA_W = 32;
    localparam int KEEP_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } gen_state_t;

    // Byte enables of a packet's final beat, from the low two bits of its length.
    function automatic logic [KEEP_W-1:0] keep_from_len(input logic [1:0] len_lo);
        logic [KEEP_W-1:0] keep;
        case (len_lo)
            2'd1:    keep = 4'b0001;
            2'd2:    keep = 4'b0011;
            2'd3:    keep = 4'b0111;
            default: keep = 4'b1111;
        endcase
        return keep;
    endfunction

endpackage

// File: rtl/rx_axis_pkt_gen.sv
// Per-lane AXI-Stream packet source: emits a programmed burst of packets whose
// beats carry {lane, packet sequence, beat index}; never stalls (no tready).
module rx_axis_pkt_gen #(
    parameter logic [7:0] LANE_ID = 8'd0,
    parameter int         DATA_W  = 32
) (
    input  logic              rx_clk,
    input  logic              rx_rst,
    input  logic              start,
    input  logic              stop,
    input  logic [15:0]       pkt_len_bytes,
    input  logic [15:0]       num_pkts,
    input  logic [7:0]        ifg_cycles,
    output logic              busy,
    output logic              done,
    output logic [15:0]       pkt_count,
    output logic              rx_axis_tvalid,
    output logic [DATA_W-1:0] rx_axis_tdata,
    output logic              rx_axis_tlast,
    output logic [3:0]        rx_axis_tkeep
);
    import rx_tx_axis_pkg::*;

    gen_state_t        state_q, state_d;
    logic [1:0]        len_lo_q, len_lo_d;
    logic [15:0]       num_q, num_d;
    logic [7:0]        ifg_q, ifg_d;
    logic [16:0]       beats_q, beats_d;
    logic [15:0]       idx_q, idx_d;
    logic [7:0]        seq_q, seq_d;
    logic [7:0]        gap_q, gap_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tvalid_q, tvalid_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic              tlast_q, tlast_d;
    logic [3:0]        tkeep_q, tkeep_d;

    logic              emit;
    logic              last_pkt;

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        num_d    = num_q;
        ifg_d    = ifg_q;
        beats_d  = beats_q;
        idx_d    = idx_q;
        seq_d    = seq_q;
        gap_d    = gap_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        tvalid_d = 1'b0;
        tdata_d  = '0;
        tlast_d  = 1'b0;
        tkeep_d  = '0;
        emit     = 1'b0;
        last_pkt = (cnt_q + 16'd1) == num_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_lo_d = pkt_len_bytes[1:0];
                    num_d    = num_pkts;
                    ifg_d    = ifg_cycles;
                    beats_d  = ({1'b0, pkt_len_bytes} + 17'd3) >> 2;
                    idx_d    = '0;
                    seq_d    = '0;
                    cnt_d    = '0;
                    if (pkt_len_bytes == 16'd0 || num_pkts == 16'd0) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SEND;
                        busy_d  = 1'b1;
                        emit    = 1'b1;
                    end
                end
            end
            SEND: begin
                if (tlast_q) begin
                    cnt_d = cnt_q + 16'd1;
                    if (last_pkt || stop) begin
                        state_d = FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (ifg_q != 8'd0) begin
                        state_d = GAP;
                        gap_d   = ifg_q;
                    end else begin
                        idx_d = '0;
                        seq_d = seq_q + 8'd1;
                        emit  = 1'b1;
                    end
                end else begin
                    idx_d = idx_q + 16'd1;
                    emit  = 1'b1;
                end
            end
            GAP: begin
                if (stop) begin
                    state_d = FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (gap_q <= 8'd1) begin
                    state_d = SEND;
                    idx_d   = '0;
                    seq_d   = seq_q + 8'd1;
                    emit    = 1'b1;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Output registers hold the beat presented next cycle, built from the
        // already-updated counters so the first beat lands right after start.
        if (emit) begin
            tvalid_d = 1'b1;
            tdata_d  = {LANE_ID, seq_d, idx_d};
            tlast_d  = ({1'b0, idx_d} + 17'd1) == beats_d;
            tkeep_d  = tlast_d ? keep_from_len(len_lo_d) : 4'b1111;
        end
    end

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            state_q  <= IDLE;
            len_lo_q <= '0;
            num_q    <= '0;
            ifg_q    <= '0;
            beats_q  <= '0;
            idx_q    <= '0;
            seq_q    <= '0;
            gap_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            tkeep_q  <= '0;
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            num_q    <= num_d;
            ifg_q    <= ifg_d;
            beats_q  <= beats_d;
            idx_q    <= idx_d;
            seq_q    <= seq_d;
            gap_q    <= gap_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            tkeep_q  <= tkeep_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pkt_count      = cnt_q;
    assign rx_axis_tvalid = tvalid_q;
    assign rx_axis_tdata  = tdata_q;
    assign rx_axis_tlast  = tlast_q;
    assign rx_axis_tkeep  = tkeep_q;

endmodule
